muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the operand/result width in bits.
REQ-002 The block SHALL have port CLK, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port START, input, 1 bit, a one-cycle request to begin an operation.
REQ-005 The block SHALL have port SELECT, input, 5 bits, the ALU op code: 01100 DIV, 01101 REM, 01110 DIVU, 01111 REMU.
REQ-006 The block SHALL have ports DATA1 (dividend) and DATA2 (divisor), input, WIDTH bits each.
REQ-007 The block SHALL have port FLUSH, input, 1 bit, a pipeline abort.
REQ-008 The block SHALL have port RESULT, output, WIDTH bits, the quotient or remainder.
REQ-009 The block SHALL have port BUSY, output, 1 bit, high while an operation is in flight; the pipeline stalls on it.
REQ-010 The block SHALL have port DONE, output, 1 bit, a one-cycle pulse marking RESULT valid.

Function
REQ-011 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-012 In IDLE, START=1 with a valid SELECT SHALL latch DATA1, DATA2 and SELECT, clear the step counter, enter CALC and raise BUSY at that same edge (edge k).
REQ-013 In IDLE, START=1 with any other SELECT code SHALL be ignored: stay in IDLE, BUSY stays 0.
REQ-014 For DIV/REM, the block SHALL latch absolute values of the operands and record the quotient sign (sign1 XOR sign2) and the remainder sign (sign1).
REQ-015 CALC SHALL run one restoring-division step per cycle for exactly WIDTH cycles (edges k+1..k+32), then enter FIX.
REQ-016 FIX SHALL apply sign correction, select quotient or remainder, load RESULT at edge k+33 and enter DONE.
REQ-017 In DONE, the block SHALL assert DONE=1 for exactly one cycle (after edge k+33), drop BUSY at edge k+34, and return to IDLE.
REQ-018 RESULT SHALL hold its value until the next FIX load, reset or early-out load.
REQ-019 START while not in IDLE SHALL be ignored, with no effect on the operation in flight.
REQ-020 FLUSH=1 in CALC, FIX or DONE SHALL return the FSM to IDLE at the next edge: BUSY=0, no DONE pulse, RESULT unchanged. FLUSH takes priority over START in the same cycle.
REQ-021 Divide by zero SHALL give quotient all-ones (DIV and DIVU) and remainder equal to DATA1.
REQ-022 Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.

Reset
REQ-023 RESET=1 SHALL immediately force state IDLE, BUSY=0, DONE=0, RESULT=0, counter=0 and clear the latched operands, including mid-operation.
REQ-024 The first START SHALL be accepted at the first rising edge after RESET deasserts.

Configuration
REQ-025 With MULDIV_EARLY_OUT_EN defined, divide-by-zero and signed overflow SHALL skip CALC/FIX: load RESULT at edge k+1 and pulse DONE in the following cycle (edge k+1 to k+2), with BUSY high for 2 cycles.
REQ-026 Without MULDIV_EARLY_OUT_EN, those cases SHALL take the full 34-cycle path, and FIX SHALL produce the REQ-021/REQ-022 values.

Structure
REQ-027 Shared package muldiv_pkg SHALL hold the FSM state enum, the four SELECT code constants and the WIDTH default.
REQ-028 One combinational sub-module, div_step, SHALL perform a single restoring step (shift, trial subtract, quotient bit); muldiv_seq instantiates it once.

Verification
REQ-029 DIVU 100/7 -> RESULT=14, DONE pulses 34 cycles after START; REMU with the same operands -> RESULT=2.
REQ-030 DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-031 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DONE at 2 cycles with MULDIV_EARLY_OUT_EN defined, 34 cycles without.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-033 FLUSH 10 cycles after START -> BUSY=0 next cycle, no DONE, RESULT unchanged; a START one cycle later completes normally.
REQ-034 RESET asserted mid-CALC (between edges) -> BUSY, DONE and RESULT go to 0 without waiting for a clock edge; a START arriving during a busy operation produces no second DONE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the sequential divider.
//   state_t        FSM encoding (IDLE, CALC, FIX, DONE)
//   OP_*           SELECT op codes accepted by muldiv_seq
//   WIDTH_DEF      default operand/result width
//   is_div_op()    true for any of the four accepted op codes
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [4:0] OP_DIV  = 5'b01100;
  localparam logic [4:0] OP_REM  = 5'b01101;
  localparam logic [4:0] OP_DIVU = 5'b01110;
  localparam logic [4:0] OP_REMU = 5'b01111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic is_div_op(input logic [4:0] sel);
    return (sel == OP_DIV) || (sel == OP_REM) || (sel == OP_DIVU) || (sel == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_seq_div_step.sv
// div_step: one combinational restoring-division step.
//   rem_in  partial remainder before the step
//   quo_in  dividend/quotient shift register before the step
//   dvsr    divisor magnitude
//   rem_out partial remainder after the step
//   quo_out shift register after the step (new quotient bit in LSB)
module div_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  // Bring the next dividend bit into the remainder, then trial subtract.
  // The extra MSB of diff is set exactly when shifted < dvsr.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr};
  assign borrow  = diff[WIDTH];

  assign rem_out = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle restoring divider (DIV/REM/DIVU/REMU).
//   CLK     clock, rising edge
//   RESET   asynchronous active-high reset
//   START   one-cycle request, sampled only in IDLE
//   SELECT  op code (see muldiv_pkg OP_*); other codes are ignored
//   DATA1   dividend, DATA2 divisor
//   FLUSH   abort the operation in flight (wins over START)
//   RESULT  quotient or remainder, held until the next load
//   BUSY    high from the accepting edge until the return to IDLE
//   DONE    one-cycle pulse while RESULT is fresh
// Optional: define MULDIV_EARLY_OUT_EN to finish divide-by-zero and
// signed overflow one cycle after acceptance instead of running CALC/FIX.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [4:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r, quo_r, dvsr_r;
  logic             neg_q, neg_r, is_rem, dz;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH-1:0] fix_res;

  // Operand conditioning at acceptance: magnitudes for the signed ops.
  logic is_signed, s1, s2;
  assign is_signed = ~SELECT[1];
  assign s1        = is_signed & DATA1[WIDTH-1];
  assign s2        = is_signed & DATA2[WIDTH-1];

`ifdef MULDIV_EARLY_OUT_EN
  logic             early;
  logic [WIDTH-1:0] early_res;
  logic             in_dz, in_ovf;
  assign in_dz  = (DATA2 == '0);
  assign in_ovf = is_signed && (DATA1 == {1'b1, {(WIDTH-1){1'b0}}}) && (DATA2 == '1);
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .dvsr    (dvsr_r),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // Sign fix-up. Divide by zero leaves an all-ones magnitude, which must not
  // be negated for DIV; the remainder path already reconstructs DATA1.
  // Signed overflow falls out naturally: -(0x80..0) == 0x80..0, remainder 0.
  always_comb begin
    fix_res = '0;
    if (is_rem)  fix_res = neg_r ? -rem_r : rem_r;
    else if (dz) fix_res = '1;
    else         fix_res = neg_q ? -quo_r : quo_r;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      dvsr_r <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
      dz     <= 1'b0;
      RESULT <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      early     <= 1'b0;
      early_res <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          DONE <= 1'b0;
          if (START && is_div_op(SELECT)) begin
            rem_r  <= '0;
            quo_r  <= s1 ? -DATA1 : DATA1;
            dvsr_r <= s2 ? -DATA2 : DATA2;
            neg_q  <= s1 ^ s2;
            neg_r  <= s1;
            is_rem <= SELECT[0];
            dz     <= (DATA2 == '0);
            cnt    <= '0;
            BUSY   <= 1'b1;
            state  <= S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
            early     <= in_dz | in_ovf;
            early_res <= in_dz ? (SELECT[0] ? DATA1 : '1)
                               : (SELECT[0] ? '0 : DATA1);
`endif
          end
        end
        S_CALC: begin
          if (FLUSH) begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
`ifdef MULDIV_EARLY_OUT_EN
          else if (early) begin
            RESULT <= early_res;
            DONE   <= 1'b1;
            state  <= S_DONE;
          end
`endif
          else begin
            rem_r <= rem_nx;
            quo_r <= quo_nx;
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
          end
        end
        S_FIX: begin
          if (FLUSH) begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end else begin
            RESULT <= fix_res;
            DONE   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          // Same exit with or without FLUSH: pulse ends, BUSY drops.
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif
  localparam int FULL_LAT = 33;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [4:0]  SELECT = '0;
  logic [31:0] DATA1 = '0;
  logic [31:0] DATA2 = '0;
  logic        FLUSH = 1'b0;
  logic [31:0] RESULT;
  logic        BUSY;
  logic        DONE;

  int tests = 0;
  int fails = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .SELECT (SELECT),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .FLUSH  (FLUSH),
    .RESULT (RESULT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge, then measure edges from acceptance to DONE.
  task automatic run_op(input string tag, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    @(negedge CLK);
    START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
    @(posedge CLK); #1;
    START = 1'b0;
    chk({tag, "_busy"}, {31'b0, BUSY}, 32'd1);
    n = 0;
    while (!DONE && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_res"}, RESULT, exp);
    @(posedge CLK); #1;
    chk({tag, "_done_off"}, {31'b0, DONE}, 32'd0);
    chk({tag, "_busy_off"}, {31'b0, BUSY}, 32'd0);
  endtask

  initial begin
    int ndone;

    // Reset state
    #12;
    chk("rst_busy", {31'b0, BUSY}, 32'd0);
    chk("rst_done", {31'b0, DONE}, 32'd0);
    chk("rst_result", RESULT, 32'd0);
    @(negedge CLK); RESET = 1'b0;

    // Basic unsigned, first START right after reset release
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, FULL_LAT);

    // Signed
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FULL_LAT);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, FULL_LAT);

    // Divide by zero
    run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, EARLY_LAT);
    run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, EARLY_LAT);
    run_op("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, EARLY_LAT);
    run_op("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, EARLY_LAT);

    // Signed overflow
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EARLY_LAT);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EARLY_LAT);

    // Invalid op code ignored
    @(negedge CLK); START = 1'b1; SELECT = 5'b00000; DATA1 = 32'd9; DATA2 = 32'd3;
    @(posedge CLK); #1; START = 1'b0;
    chk("bad_sel_busy", {31'b0, BUSY}, 32'd0);
    @(posedge CLK); #1;
    chk("bad_sel_done", {31'b0, DONE}, 32'd0);

    // Put a known value in RESULT before the flush
    run_op("divu_pre", OP_DIVU, 32'd100, 32'd7, 32'd14, FULL_LAT);

    // Flush 10 cycles into CALC, with a competing START
    @(negedge CLK); START = 1'b1; SELECT = OP_DIVU; DATA1 = 32'd1000; DATA2 = 32'd3;
    @(posedge CLK); #1; START = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK); FLUSH = 1'b1; START = 1'b1; SELECT = OP_DIVU;
    @(posedge CLK); #1; FLUSH = 1'b0; START = 1'b0;
    chk("flush_busy", {31'b0, BUSY}, 32'd0);
    chk("flush_done", {31'b0, DONE}, 32'd0);
    chk("flush_result", RESULT, 32'd14);
    @(posedge CLK); #1;
    chk("flush_idle_busy", {31'b0, BUSY}, 32'd0);
    run_op("after_flush", OP_DIVU, 32'd1000, 32'd3, 32'd333, FULL_LAT);

    // START while busy: no second DONE, original result kept
    @(negedge CLK); START = 1'b1; SELECT = OP_DIVU; DATA1 = 32'd100; DATA2 = 32'd7;
    @(posedge CLK); #1; START = 1'b0;
    repeat (4) @(posedge CLK);
    @(negedge CLK); START = 1'b1; SELECT = OP_REMU; DATA1 = 32'd9; DATA2 = 32'd4;
    @(posedge CLK); #1; START = 1'b0;
    ndone = 0;
    repeat (50) begin
      @(posedge CLK); #1;
      if (DONE) ndone++;
    end
    chk("busy_start_ndone", ndone, 32'd1);
    chk("busy_start_res", RESULT, 32'd14);
    chk("busy_start_idle", {31'b0, BUSY}, 32'd0);

    // Asynchronous reset mid-CALC
    @(negedge CLK); START = 1'b1; SELECT = OP_REMU; DATA1 = 32'd100; DATA2 = 32'd7;
    @(posedge CLK); #1; START = 1'b0;
    repeat (5) @(posedge CLK);
    #2; RESET = 1'b1;
    #1;
    chk("arst_busy", {31'b0, BUSY}, 32'd0);
    chk("arst_done", {31'b0, DONE}, 32'd0);
    chk("arst_result", RESULT, 32'd0);
    @(negedge CLK); RESET = 1'b0;

    // Mixed signs, first START after reset
    run_op("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, FULL_LAT);
    run_op("rem_100_m7", OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, FULL_LAT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
